// File: rtl/z80_bus_responder_if.sv
// Pad-side Z80 bus bundle between the core (master) and the bus responder
// (slave), plus the bring-up trace port.
interface z80_bus_responder_if;
   logic [15:0] addr;
   logic [7:0]  cpu_dout;
   logic        mreq_n;
   logic        iorq_n;
   logic        rd_n;
   logic        wr_n;
   logic        m1_n;
   logic        rfsh_n;
   logic [7:0]  cpu_din;
   logic        cpu_din_oe;
   logic        wait_n;
   logic        trace_valid;
   logic        trace_ready;
   logic [26:0] trace_data;
   logic [7:0]  trace_ovf;

   modport master (
      output addr, cpu_dout, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
      output trace_ready,
      input  cpu_din, cpu_din_oe, wait_n,
      input  trace_valid, trace_data, trace_ovf
   );

   modport slave (
      input  addr, cpu_dout, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
      input  trace_ready,
      output cpu_din, cpu_din_oe, wait_n,
      output trace_valid, trace_data, trace_ovf
   );
endinterface

// File: rtl/z80_bus_responder.sv
// Z80 external-bus target: RAM, loopback I/O port, INTA vector, wait states.
// Trace FIFO and trace_ovf are built only when Z80_BUS_TRACE_EN is defined.
module z80_bus_responder #(
   parameter int         MEM_AW      = 8,
   parameter int         WAIT_STATES = 1,
   parameter logic [7:0] IO_PORT     = 8'h00,
   parameter logic [7:0] INT_VECTOR  = 8'hFF,
   parameter int         TRACE_DEPTH = 8
) (
   input logic                wb_clk_i,
   input logic                wb_rst_i,
   z80_bus_responder_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE, S_HOLD} state_t;

   localparam logic [2:0] T_NONE = 3'd0;
   localparam logic [2:0] T_MRD  = 3'd1;
   localparam logic [2:0] T_MWR  = 3'd2;
   localparam logic [2:0] T_IORD = 3'd3;
   localparam logic [2:0] T_IOWR = 3'd4;
   localparam logic [2:0] T_INTA = 3'd5;
   localparam logic [3:0] WS_LOAD =
      (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   logic [15:0] r_addr;
   logic [7:0]  r_dout;
   logic        r_mreq_n, r_iorq_n, r_rd_n, r_wr_n, r_m1_n, r_rfsh_n;

   state_t      r_state;
   logic [2:0]  r_type;
   logic [15:0] r_caddr;
   logic [3:0]  r_cnt;
   logic [7:0]  r_din;
   logic        r_oe;
   logic        r_wait_n;
   logic [7:0]  r_io;
   logic [7:0]  r_data;
   logic [7:0]  r_ram [2**MEM_AW];

   logic [2:0]  w_dec;
   logic        w_live;
   logic        w_in_range;
   logic        w_is_rd;
   logic [7:0]  w_ram_q;
   logic [7:0]  w_rd_val;
   logic        w_ram_we;
   logic        w_push;
   logic [26:0] w_entry;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_addr   <= '0;
         r_dout   <= '0;
         r_mreq_n <= 1'b1;
         r_iorq_n <= 1'b1;
         r_rd_n   <= 1'b1;
         r_wr_n   <= 1'b1;
         r_m1_n   <= 1'b1;
         r_rfsh_n <= 1'b1;
      end else begin
         r_addr   <= bus.addr;
         r_dout   <= bus.cpu_dout;
         r_mreq_n <= bus.mreq_n;
         r_iorq_n <= bus.iorq_n;
         r_rd_n   <= bus.rd_n;
         r_wr_n   <= bus.wr_n;
         r_m1_n   <= bus.m1_n;
         r_rfsh_n <= bus.rfsh_n;
      end
   end

   // Refresh wins over memory read/write so it is never waited or traced.
   always_comb begin
      w_dec = T_NONE;
      priority case (1'b1)
         (!r_mreq_n && !r_rfsh_n): w_dec = T_NONE;
         (!r_mreq_n && !r_rd_n):   w_dec = T_MRD;
         (!r_mreq_n && !r_wr_n):   w_dec = T_MWR;
         (!r_iorq_n && !r_m1_n):   w_dec = T_INTA;
         (!r_iorq_n && !r_rd_n):   w_dec = T_IORD;
         (!r_iorq_n && !r_wr_n):   w_dec = T_IOWR;
         default:                  w_dec = T_NONE;
      endcase
   end

   always_comb begin
      w_live = 1'b0;
      case (r_type)
         T_MRD:   w_live = !r_mreq_n && !r_rd_n;
         T_MWR:   w_live = !r_mreq_n && !r_wr_n;
         T_IORD:  w_live = !r_iorq_n && !r_rd_n;
         T_IOWR:  w_live = !r_iorq_n && !r_wr_n;
         T_INTA:  w_live = !r_iorq_n && !r_m1_n;
         default: w_live = 1'b0;
      endcase
   end

   assign w_in_range = (r_caddr >> MEM_AW) == 16'd0;
   assign w_is_rd    = (r_type == T_MRD) || (r_type == T_IORD) ||
                       (r_type == T_INTA);
   assign w_ram_q    = r_ram[r_caddr[MEM_AW-1:0]];

   always_comb begin
      w_rd_val = 8'hFF;
      case (r_type)
         T_MRD:   if (w_in_range) w_rd_val = w_ram_q;
         T_IORD:  if (r_caddr[7:0] == IO_PORT) w_rd_val = r_io;
         T_INTA:  w_rd_val = INT_VECTOR;
         default: w_rd_val = 8'hFF;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state  <= S_IDLE;
         r_type   <= T_NONE;
         r_caddr  <= '0;
         r_cnt    <= '0;
         r_din    <= '0;
         r_oe     <= 1'b0;
         r_wait_n <= 1'b1;
         r_io     <= '0;
         r_data   <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_dec != T_NONE) begin
                  r_type  <= w_dec;
                  r_caddr <= r_addr;
                  r_cnt   <= WS_LOAD;
                  if (WAIT_STATES == 0) begin
                     r_state <= S_ACTIVE;
                  end else begin
                     r_state  <= S_WAIT;
                     r_wait_n <= 1'b0;
                  end
               end
            end
            S_WAIT: begin
               if (!w_live) begin
                  r_wait_n <= 1'b1;
                  r_state  <= S_IDLE;
               end else if (r_cnt == 4'd0) begin
                  r_wait_n <= 1'b1;
                  r_state  <= S_ACTIVE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_ACTIVE: begin
               if (!w_live) begin
                  r_oe    <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_HOLD;
                  if (w_is_rd) begin
                     r_din  <= w_rd_val;
                     r_data <= w_rd_val;
                     r_oe   <= 1'b1;
                  end else begin
                     r_data <= r_dout;
                     if (r_type == T_IOWR && r_caddr[7:0] == IO_PORT)
                        r_io <= r_dout;
                  end
               end
            end
            S_HOLD: begin
               if (!w_live) begin
                  r_oe    <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign w_ram_we = (r_state == S_ACTIVE) && w_live && (r_type == T_MWR) &&
                     w_in_range && !wb_rst_i;

   always_ff @(posedge wb_clk_i) begin
      if (w_ram_we) r_ram[r_caddr[MEM_AW-1:0]] <= r_dout;
   end

   assign w_push  = (r_state == S_HOLD) && !w_live;
   assign w_entry = {r_type, r_caddr, r_data};

   assign bus.cpu_din    = r_din;
   assign bus.cpu_din_oe = r_oe;
   assign bus.wait_n     = r_wait_n;

`ifdef Z80_BUS_TRACE_EN
   localparam int PW = $clog2(TRACE_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(TRACE_DEPTH);

   logic [26:0] r_fifo [TRACE_DEPTH];
   logic [PW-1:0] r_wp, r_rp;
   logic [PW:0]   r_fcnt;
   logic [7:0]    r_ovf;
   logic          w_full, w_pop, w_wr;

   assign w_full = r_fcnt == DEPTH_C;
   assign w_pop  = (r_fcnt != '0) && bus.trace_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_wr   = w_push && (!w_full || w_pop);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_wp   <= '0;
         r_rp   <= '0;
         r_fcnt <= '0;
         r_ovf  <= '0;
      end else begin
         if (w_pop) r_rp <= r_rp + 1'b1;
         if (w_wr) r_wp <= r_wp + 1'b1;
         else if (w_push && r_ovf != 8'hFF) r_ovf <= r_ovf + 8'd1;
         if (w_wr && !w_pop) r_fcnt <= r_fcnt + 1'b1;
         else if (!w_wr && w_pop) r_fcnt <= r_fcnt - 1'b1;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (w_wr) r_fifo[r_wp] <= w_entry;
   end

   assign bus.trace_valid = r_fcnt != '0;
   assign bus.trace_data  = (r_fcnt != '0) ? r_fifo[r_rp] : 27'd0;
   assign bus.trace_ovf   = r_ovf;
`else
   logic w_unused_trace;
   assign w_unused_trace  = ^{bus.trace_ready, w_push, w_entry};
   assign bus.trace_valid = 1'b0;
   assign bus.trace_data  = 27'd0;
   assign bus.trace_ovf   = 8'd0;
`endif
endmodule

// File: doc/z80_bus_responder.md
Name: z80_bus_responder

Overview:
- External-bus target for the Z80 core; consumes the core's pad-side bus outputs (address, control strobes, data out) and drives the data-in pads and WAIT_n.
- Provides on-chip RAM, one loopback I/O port, an interrupt-acknowledge vector, programmable wait states and a transaction trace FIFO for bring-up.
- Lets the core run standalone in silicon and in simulation without external memory.

Parameters:
- MEM_AW, 8: RAM address width; RAM is 2^MEM_AW bytes at 0x0000 upward.
- WAIT_STATES, 1: wait_n low cycles per decoded cycle, 0..15.
- IO_PORT, 8'h00: low address byte of the loopback I/O register.
- INT_VECTOR, 8'hFF: byte returned during interrupt acknowledge (RST 38h).
- TRACE_DEPTH, 8: trace FIFO entries, power of two, at least 2.

Ports:
- wb_clk_i  in  1  single clock; bus inputs are synchronous to it.
- wb_rst_i  in  1  synchronous reset, active-high.
- addr  in  16  Z80 address bus.
- cpu_dout  in  8  Z80 data out, valid while wr_n low.
- mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n  in  1 each  Z80 control strobes.
- cpu_din  out  8  data to Z80 data-in pads.
- cpu_din_oe  out  1  1 = responder drives cpu_din.
- wait_n  out  1  Z80 WAIT_n.
- trace_valid  out  1  FIFO non-empty.
- trace_ready  in  1  consumer pop.
- trace_data  out  27  {type[2:0], addr[15:0], data[7:0]}.
- trace_ovf  out  8  dropped-entry count, saturating.

Behaviour:
- All inputs are registered once. Decode uses registered values. Outputs are registered.
- Reset values: cpu_din=0, cpu_din_oe=0, wait_n=1, trace_valid=0, trace_data=0, trace_ovf=0, io_reg=0, FSM=IDLE, FIFO empty. RAM is not cleared.
- Cycle types (type code):
  - MEM_RD=1: mreq_n=0, rd_n=0, rfsh_n=1.
  - MEM_WR=2: mreq_n=0, wr_n=0.
  - IO_RD=3: iorq_n=0, rd_n=0, m1_n=1.
  - IO_WR=4: iorq_n=0, wr_n=0.
  - INTA=5: iorq_n=0, m1_n=0.
  - Refresh (mreq_n=0, rfsh_n=0) is ignored: never waited, never traced.
- FSM states: IDLE, WAIT, ACTIVE, HOLD.
  - IDLE: a decoded cycle is seen at registered cycle N. Latch type and addr, enter WAIT at N+1 with wait_n=0. If WAIT_STATES=0, go straight to ACTIVE.
  - WAIT: a 4-bit counter holds wait_n=0 for exactly WAIT_STATES cycles, then moves to ACTIVE with wait_n=1.
  - ACTIVE, one cycle:
    - Read types: cpu_din is loaded and cpu_din_oe=1.
    - MEM_RD returns ram[addr[MEM_AW-1:0]] if addr < 2^MEM_AW, else 8'hFF.
    - IO_RD returns io_reg if addr[7:0]==IO_PORT, else 8'hFF.
    - INTA returns INT_VECTOR.
    - Write types sample cpu_dout. MEM_WR writes RAM only when in range. IO_WR to IO_PORT updates io_reg. All other writes are discarded.
  - HOLD: cpu_din and cpu_din_oe are held until the active strobes (rd_n/wr_n and mreq_n/iorq_n) are seen deasserted. Then: cpu_din_oe=0, push a trace entry, go to IDLE.
- Trace entry data field: read data for reads, cpu_dout for writes.
- Strobe released during WAIT or ACTIVE: abort. wait_n=1, cpu_din_oe=0, no write commit if still in WAIT, no trace entry, return to IDLE.
- A new strobe pattern is never decoded until after the return to IDLE, so back-to-back cycles need one IDLE cycle minimum.
- FIFO:
  - First-word-fall-through; trace_data is valid whenever trace_valid=1.
  - Pop on trace_valid & trace_ready.
  - Push when full and no pop in the same cycle: entry dropped, trace_ovf += 1, saturating at 255.
  - Push and pop in the same cycle while full: both succeed.
  - Pointers wrap modulo TRACE_DEPTH.
- wb_rst_i mid-cycle: all outputs return to reset values on the next edge. A pending write is not committed.

Optional Feature:
- Macro: Z80_BUS_TRACE_EN.
- Defined: trace FIFO and trace_ovf are implemented as above.
- Undefined: no FIFO storage is built. trace_valid=0, trace_data=0 and trace_ovf=0 constantly. trace_ready is ignored. Bus behaviour is identical.

Test Plan:
- WAIT_STATES=2, MEM_WR addr 0x0010 data 0x5A, then MEM_RD 0x0010 -> wait_n low for exactly 2 cycles in each cycle; read cpu_din=0x5A with cpu_din_oe=1 until rd_n rises; trace entries {2,0x0010,0x5A} then {1,0x0010,0x5A}.
- MEM_RD at 0x1234 (out of range, MEM_AW=8) -> cpu_din=0xFF, RAM unchanged; IO_WR port 0x00 data 0xC3 then IO_RD port 0x00 -> 0xC3; IO_RD port 0x01 -> 0xFF.
- INTA (m1_n=0, iorq_n=0) -> cpu_din=0xFF, type 5 traced; refresh cycle (mreq_n=0, rfsh_n=0) -> wait_n stays 1, no trace entry.
- trace_ready=0, 10 completed cycles with TRACE_DEPTH=8 -> trace_valid=1, trace_ovf=2; then drain -> 8 entries in order, trace_valid falls after the 8th pop.
- wr_n released during WAIT (WAIT_STATES=4) -> wait_n back to 1 next cycle, no RAM write, no trace; separately, wb_rst_i asserted in HOLD -> cpu_din_oe=0, wait_n=1, FIFO empty, trace_ovf=0 next cycle.
- Build without Z80_BUS_TRACE_EN and rerun the first scenario -> identical bus responses; trace_valid remains 0 throughout.
